// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write/two-read register file with clear sequencer and pending-write scoreboard
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr0,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     busy_count
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   clr_ptr;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend, pend_d;
  logic [AW:0]     count_d;
  logic            wr0_ok, wr1_ok, iss_ok;
  logic [AW-1:0]   ra [2];
  logic [XLEN-1:0] rd [2];
  logic            rb [2];

  assign ready = (state == READY);

  // Effective operations: only in READY, never during a reset edge, never to a hardwired r0
  assign wr0_ok = ready && !reset && we0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign wr1_ok = ready && !reset && we1 && !(ZERO_REG != 0 && waddr1 == '0);
  assign iss_ok = ready && !reset && issue_valid && !(ZERO_REG != 0 && issue_rd == '0);

  // Next-state logic: CLEAR ends on the edge that clears the last register
  always_comb begin
    state_d = state;
    case (state)
      CLEAR:   if (clr_ptr == AW'(NREGS - 1)) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // State and clear pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_d;
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Register array: zeroing during CLEAR, port 1 written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      regs[clr_ptr] <= '0;
    end else begin
      if (wr0_ok) regs[waddr0] <= wdata0;
      if (wr1_ok) regs[waddr1] <= wdata1;
    end
  end

  // Scoreboard next value: writes clear, an issue applied afterwards re-sets (new producer wins)
  always_comb begin
    pend_d = pend;
    if (wr0_ok) pend_d[waddr0] = 1'b0;
    if (wr1_ok) pend_d[waddr1] = 1'b0;
    if (iss_ok) pend_d[issue_rd] = 1'b1;
    count_d = '0;
    for (int i = 0; i < NREGS; i++) count_d = count_d + {{AW{1'b0}}, pend_d[i]};
  end

  // Scoreboard and its population count, registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      busy_count <= '0;
    end else begin
      pend       <= pend_d;
      busy_count <= count_d;
    end
  end

  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;

  // Read ports: zero during CLEAR, r0 hardwired, optional same-cycle write forwarding
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      rb[p] = 1'b0;
      if (ready && !(ZERO_REG != 0 && ra[p] == '0)) begin
        rd[p] = regs[ra[p]];
        rb[p] = pend[ra[p]];
        if (BYPASS != 0) begin
          if (wr1_ok && waddr1 == ra[p])      rd[p] = wdata1;
          else if (wr0_ok && waddr0 == ra[p]) rd[p] = wdata0;
          if (((wr0_ok && waddr0 == ra[p]) || (wr1_ok && waddr1 == ra[p])) &&
              !(iss_ok && issue_rd == ra[p]))
            rb[p] = 1'b0;
        end
      end
    end
  end

  assign rs1_data = rd[0];
  assign rs2_data = rd[1];
  assign rs1_busy = rb[0];
  assign rs2_busy = rb[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, default and BYPASS=0/ZERO_REG=0 instances
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic clk = 0;
  logic reset;
  logic [AW-1:0] rs1_addr, rs2_addr, waddr0, waddr1, issue_rd;
  logic we0, we1, issue_valid;
  logic [XLEN-1:0] wdata0, wdata1;

  logic ready_a, ready_b, rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b;
  logic [XLEN-1:0] rs1_data_a, rs2_data_a, rs1_data_b, rs2_data_b;
  logic [AW:0] busy_count_a, busy_count_b;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t exp_q[$];
  logic [31:0] obs_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .ready(ready_a),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_a), .rs2_data(rs2_data_a),
    .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_count(busy_count_a)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(reset), .ready(ready_b),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
    .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_count(busy_count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; issue_valid = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_rd = '0;
  endtask

  task automatic expect_v(input string name, input logic [31:0] exp, input logic [31:0] obs);
    exp_t e;
    e.name = name;
    e.exp = exp;
    exp_q.push_back(e);
    obs_q.push_back(obs);
  endtask

  task automatic test_reset();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < NREGS; i++) begin
      expect_v("ready_a_clear", 0, {31'b0, ready_a});
      expect_v("ready_b_clear", 0, {31'b0, ready_b});
      if (i == 3) begin
        expect_v("clear_read_b", 0, rs1_data_b);
        expect_v("clear_count_a", 0, {26'b0, busy_count_a});
      end
      step();
    end
    expect_v("ready_a_up", 1, {31'b0, ready_a});
    expect_v("ready_b_up", 1, {31'b0, ready_b});
    for (int a = 0; a < NREGS; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a);
      #1;
      expect_v("reset_rd_a1", 0, rs1_data_a);
      expect_v("reset_rd_b2", 0, rs2_data_b);
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_dual_write();
    idle();
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hAAAA0000;
    we1 = 1; waddr1 = 5'd5; wdata1 = 32'h5555FFFF;
    rs1_addr = 5'd5;
    #1;
    expect_v("bypass_a", 32'h5555FFFF, rs1_data_a);
    expect_v("nobypass_b", 32'h0, rs1_data_b);
    step();
    idle();
    #1;
    expect_v("collide_a", 32'h5555FFFF, rs1_data_a);
    expect_v("collide_b", 32'h5555FFFF, rs1_data_b);
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h00000011;
    we1 = 1; waddr1 = 5'd4; wdata1 = 32'h00000022;
    step();
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    expect_v("dual_r3_a", 32'h11, rs1_data_a);
    expect_v("dual_r4_a", 32'h22, rs2_data_a);
    expect_v("dual_r3_b", 32'h11, rs1_data_b);
    expect_v("dual_r4_b", 32'h22, rs2_data_b);
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF;
    step();
    idle();
    rs1_addr = 5'd0;
    #1;
    expect_v("r0_a", 32'h0, rs1_data_a);
    expect_v("r0_b", 32'hDEADBEEF, rs1_data_b);
    expect_v("r0_busy_a", 0, {31'b0, rs1_busy_a});
    issue_valid = 1; issue_rd = 5'd0;
    step();
    idle();
    #1;
    expect_v("r0_iss_busy_a", 0, {31'b0, rs1_busy_a});
    expect_v("r0_iss_cnt_a", 0, {26'b0, busy_count_a});
    expect_v("r0_iss_busy_b", 1, {31'b0, rs1_busy_b});
    expect_v("r0_iss_cnt_b", 1, {26'b0, busy_count_b});
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'h12345678;
    #1;
    expect_v("r0_pre_a", 32'h0, rs1_data_a);
    expect_v("r0_pre_b", 32'hDEADBEEF, rs1_data_b);
    step();
    idle();
    #1;
    expect_v("r0_post_b", 32'h12345678, rs1_data_b);
    expect_v("r0_post_cnt_b", 0, {26'b0, busy_count_b});
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    issue_valid = 1; issue_rd = 5'd7;
    step();
    idle();
    #1;
    expect_v("iss7_busy_a", 1, {31'b0, rs1_busy_a});
    expect_v("iss7_cnt_a", 1, {26'b0, busy_count_a});
    expect_v("iss7_busy_b", 1, {31'b0, rs1_busy_b});
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h77;
    #1;
    expect_v("wr7_fwd_busy_a", 0, {31'b0, rs1_busy_a});
    expect_v("wr7_nofwd_busy_b", 1, {31'b0, rs1_busy_b});
    step();
    idle();
    #1;
    expect_v("wr7_busy_a", 0, {31'b0, rs1_busy_a});
    expect_v("wr7_cnt_a", 0, {26'b0, busy_count_a});
    expect_v("wr7_cnt_b", 0, {26'b0, busy_count_b});
    issue_valid = 1; issue_rd = 5'd7;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h78;
    #1;
    expect_v("isswr7_pre_busy_a", 0, {31'b0, rs1_busy_a});
    step();
    idle();
    #1;
    expect_v("isswr7_busy_a", 1, {31'b0, rs1_busy_a});
    expect_v("isswr7_cnt_a", 1, {26'b0, busy_count_a});
    expect_v("isswr7_busy_b", 1, {31'b0, rs1_busy_b});
    issue_valid = 1; issue_rd = 5'd7;
    step();
    issue_rd = 5'd9;
    step();
    idle();
    #1;
    expect_v("reiss_cnt_a", 2, {26'b0, busy_count_a});
    expect_v("iss9_busy_a", 1, {31'b0, rs2_busy_a});
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h1;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h2;
    step();
    idle();
    #1;
    expect_v("clr_both_cnt_a", 0, {26'b0, busy_count_a});
    expect_v("clr_both_cnt_b", 0, {26'b0, busy_count_b});
    expect_v("r9_data_a", 32'h2, rs2_data_a);
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    idle();
    reset = 1;
    step();
    reset = 0;
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hFFFFFFFF;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'hCAFEF00D;
    issue_valid = 1; issue_rd = 5'd3;
    for (int i = 0; i < 10; i++) step();
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < NREGS; i++) begin
      expect_v("mid_ready_a", 0, {31'b0, ready_a});
      expect_v("mid_ready_b", 0, {31'b0, ready_b});
      step();
    end
    idle();
    expect_v("mid_ready_up_a", 1, {31'b0, ready_a});
    expect_v("mid_ready_up_b", 1, {31'b0, ready_b});
    expect_v("mid_cnt_a", 0, {26'b0, busy_count_a});
    expect_v("mid_cnt_b", 0, {26'b0, busy_count_b});
    for (int a = 0; a < NREGS; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(a);
      #1;
      expect_v("mid_rd_a", 0, rs1_data_a);
      expect_v("mid_rd_b", 0, rs2_data_b);
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    rs1_addr = '0; rs2_addr = '0;
    idle();
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
